keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_pkg.sv | 43 ++++
 rtl/sync_2ff.sv | 34 +++
 rtl/keypad_scanner.sv | 215 +++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and constants for the 4x4 keypad scanner
//
// Purpose: FSM state encoding, the row/column to hex-code key map and small
// helpers for decoding a sampled row pattern. No ports (package).
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN        = 2'd0,
    DEB_PRESS   = 2'd1,
    HELD        = 2'd2,
    DEB_RELEASE = 2'd3
  } state_e;

  // Indexed by {row, col}; entry 0 is row 0 / col 0.
  // Layout on the pad:  r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: 0 F E D
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hE, 4'hF, 4'h0,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  // True when exactly one active-low row line is asserted.
  function automatic logic single_row_low(input logic [3:0] rows_n);
    logic hit;
    hit = (rows_n == 4'b1110) || (rows_n == 4'b1101) ||
          (rows_n == 4'b1011) || (rows_n == 4'b0111);
    return hit;
  endfunction

  // Row number of the single low line; only meaningful when single_row_low().
  function automatic logic [1:0] row_index(input logic [3:0] rows_n);
    logic [1:0] idx;
    case (rows_n)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for asynchronous level inputs
//
// Purpose: brings an asynchronous bus into the clk domain with two flops.
// Ports:
//   clk_i    system clock, rising edge
//   reset_i  synchronous active-high reset, loads RESET_VAL into both flops
//   d_i      asynchronous input bus (WIDTH bits)
//   q_o      synchronized output, two cycles behind d_i
module sync_2ff #(
  parameter int                 WIDTH     = 4,
  parameter logic [WIDTH-1:0]   RESET_VAL = '1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with debounce
//
// Purpose: strobes one column at a time, detects a single pressed key,
// debounces press and release, and reports the key's hex code.
// Optional feature: define KEYPAD_REPEAT_EN to get auto-repeat pulses on
// key_valid while a key stays held.
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   rows[3:0]  keypad rows, active-low, externally pulled up (asynchronous)
//   cols[3:0]  column strobes, active-low, exactly one low at all times
//   key_code   hex code of the last accepted key, held until the next one
//   key_valid  one-cycle pulse per accepted key (and per repeat if enabled)
//   key_held   high from acceptance until the release is debounced
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CYC = 150000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  // Terminal counts; counters run 0 .. N-1.
  localparam logic [31:0] SCAN_LAST = 32'(SCAN_DIV - 1);
  localparam logic [31:0] DEB_LAST  = 32'(DEBOUNCE_CYC - 1);

  // The synchronizer costs two cycles, so a column must be driven at least
  // three cycles before its rows are meaningful at the sample point.
  if (SCAN_DIV < 3 || DEBOUNCE_CYC < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1)
  begin : g_bad_cfg
    $error("keypad_scanner: SCAN_DIV must be >= 3, other counts >= 1");
  end

  logic [3:0]  rs;

  state_e      state_q, state_d;
  logic [1:0]  col_q, col_d;
  logic [31:0] div_q, div_d;
  logic [31:0] deb_q, deb_d;
  logic [3:0]  pat_q, pat_d;
  logic [3:0]  code_q, code_d;
  logic        valid_q, valid_d;
  logic        held_q, held_d;

  sync_2ff #(
    .WIDTH     (4),
    .RESET_VAL (4'hF)
  ) u_row_sync (
    .clk_i   (clk),
    .reset_i (reset),
    .d_i     (rows),
    .q_o     (rs)
  );

`ifdef KEYPAD_REPEAT_EN
  localparam logic [31:0] RPT_FIRST_LAST = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0] RPT_NEXT_LAST  = 32'(REPEAT_RATE - 1);

  logic [31:0] rpt_q, rpt_d;
  // Low until the first repeat has fired; selects delay vs. rate interval.
  logic        rpt_phase_q, rpt_phase_d;
`endif

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SCAN;
      col_q   <= 2'd0;
      div_q   <= '0;
      deb_q   <= '0;
      pat_q   <= 4'hF;
      code_q  <= 4'h0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      div_q   <= div_d;
      deb_q   <= deb_d;
      pat_q   <= pat_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      held_q  <= held_d;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rpt_q       <= '0;
      rpt_phase_q <= 1'b0;
    end else begin
      rpt_q       <= rpt_d;
      rpt_phase_q <= rpt_phase_d;
    end
  end
`endif

  // ---------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    div_d   = div_q;
    deb_d   = deb_q;
    pat_d   = pat_q;
    code_d  = code_q;
    valid_d = 1'b0;
    held_d  = held_q;
`ifdef KEYPAD_REPEAT_EN
    rpt_d       = rpt_q;
    rpt_phase_d = rpt_phase_q;
`endif

    case (state_q)
      SCAN: begin
        if (div_q == SCAN_LAST) begin
          div_d = '0;
          // Two or more rows low on one column can be a ghost of a third
          // key elsewhere, so only a single low row is trusted.
          if (single_row_low(rs)) begin
            pat_d   = rs;
            deb_d   = '0;
            state_d = DEB_PRESS;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          div_d = div_q + 32'd1;
        end
      end

      DEB_PRESS: begin
        if (rs != pat_q) begin
          // Bounce: rescan the same column from scratch.
          div_d   = '0;
          deb_d   = '0;
          state_d = SCAN;
        end else if (deb_q == DEB_LAST) begin
          deb_d   = '0;
          code_d  = KEY_MAP[{row_index(pat_q), col_q}];
          valid_d = 1'b1;
          held_d  = 1'b1;
          state_d = HELD;
        end else begin
          deb_d = deb_q + 32'd1;
        end
      end

      HELD: begin
        // Any non-idle pattern (including a second key) keeps us here.
        if (rs == 4'hF) begin
          deb_d   = '0;
          state_d = DEB_RELEASE;
        end
      end

      DEB_RELEASE: begin
        if (rs != 4'hF) begin
          deb_d   = '0;
          state_d = HELD;
        end else if (deb_q == DEB_LAST) begin
          deb_d   = '0;
          div_d   = '0;
          held_d  = 1'b0;
          col_d   = col_q + 2'd1;
          state_d = SCAN;
        end else begin
          deb_d = deb_q + 32'd1;
        end
      end

      default: begin
        state_d = SCAN;
      end
    endcase

`ifdef KEYPAD_REPEAT_EN
    // The repeat timer only advances in HELD and is only cleared on a fresh
    // acceptance, so a short glitch through DEB_RELEASE just pauses it.
    if (state_q == DEB_PRESS && state_d == HELD) begin
      rpt_d       = '0;
      rpt_phase_d = 1'b0;
    end else if (state_q == HELD) begin
      if (rpt_q == (rpt_phase_q ? RPT_NEXT_LAST : RPT_FIRST_LAST)) begin
        rpt_d       = '0;
        rpt_phase_d = 1'b1;
        valid_d     = 1'b1;
      end else begin
        rpt_d = rpt_q + 32'd1;
      end
    end
`endif
  end

  // Decoded from the column index register, so a single low bit is
  // guaranteed structurally in every state and during reset.
  assign cols      = ~(4'b0001 << col_q);
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed self-checking bench for keypad_scanner
module tb_keypad_scanner;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CYC = 8;
  localparam int REPEAT_DELAY = 40;
  localparam int REPEAT_RATE  = 10;

`ifdef KEYPAD_REPEAT_EN
  localparam int EXP_A_PULSES = 5;
  localparam logic EXP_RPT64  = 1'b1;
`else
  localparam int EXP_A_PULSES = 1;
  localparam logic EXP_RPT64  = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;

  // pressed[r*4+c] models a closed switch between row r and column c.
  logic [15:0] pressed = '0;

  int tests  = 0;
  int fails  = 0;
  int cyc    = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !cols[c]) rows[r] = 1'b0;
  end

  keypad_scanner #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rows      (rows),
    .cols      (cols),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; outputs are looked at on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (key_valid) pulses++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  // Leaves the bench just after the last reset edge; the next rising edge
  // is cycle 1.
  task automatic do_reset();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    cyc    = 0;
    pulses = 0;
  endtask

  initial begin
    @(negedge clk);

    // Reset values and idle scanning
    pressed = '0;
    reset   = 1'b1;
    repeat (3) step();
    check("rst_cols",  {28'd0, cols},     32'hE);
    check("rst_code",  {28'd0, key_code}, 32'h0);
    check("rst_valid", {31'd0, key_valid}, 32'd0);
    check("rst_held",  {31'd0, key_held},  32'd0);
    reset = 1'b0; cyc = 0; pulses = 0;
    run_to(3);  check("scan_c0",    {28'd0, cols}, 32'hE);
    run_to(4);  check("scan_c1",    {28'd0, cols}, 32'hD);
    run_to(8);  check("scan_c2",    {28'd0, cols}, 32'hB);
    run_to(12); check("scan_c3",    {28'd0, cols}, 32'h7);
    run_to(16); check("scan_wrap",  {28'd0, cols}, 32'hE);
    run_to(40); check("idle_pulses", pulses, 0);

    // Key 6 (row1/col2): accept, hold, release
    pressed = '0; pressed[1*4+2] = 1'b1;
    do_reset();
    run_to(19); check("k6_early",  pulses, 0);
    run_to(20);
    check("k6_valid", {31'd0, key_valid}, 32'd1);
    check("k6_code",  {28'd0, key_code},  32'h6);
    check("k6_held",  {31'd0, key_held},  32'd1);
    run_to(30); pressed = '0;
    run_to(40); check("k6_held_deb", {31'd0, key_held}, 32'd1);
    run_to(41);
    check("k6_released", {31'd0, key_held}, 32'd0);
    check("k6_resume_c3", {28'd0, cols}, 32'h7);
    run_to(45); check("k6_next_c0", {28'd0, cols}, 32'hE);
    check("k6_pulses", pulses, 1);

    // Key 0 (row3/col0) with a bounce five cycles into debounce
    pressed = '0; pressed[3*4+0] = 1'b1;
    do_reset();
    run_to(7);  pressed = '0;
    run_to(8);  pressed[3*4+0] = 1'b1;
    run_to(21); check("bnc_no_early", pulses, 0);
    run_to(22);
    check("bnc_valid", {31'd0, key_valid}, 32'd1);
    check("bnc_code",  {28'd0, key_code},  32'h0);
    run_to(40); check("bnc_pulses", pulses, 1);

    // Ghost: rows 0 and 2 both low on column 1
    pressed = '0; pressed[0*4+1] = 1'b1; pressed[2*4+1] = 1'b1;
    do_reset();
    run_to(8);  check("ghost_advance", {28'd0, cols}, 32'hB);
    run_to(40);
    check("ghost_pulses", pulses, 0);
    check("ghost_held",   {31'd0, key_held}, 32'd0);

    // Reset during DEB_PRESS and during HELD (key 1, row0/col0)
    pressed = '0; pressed[0] = 1'b1;
    do_reset();
    run_to(6);  reset = 1'b1;
    step();
    check("rdp_valid", {31'd0, key_valid}, 32'd0);
    check("rdp_cols",  {28'd0, cols},      32'hE);
    step();
    check("rdp_valid2", {31'd0, key_valid}, 32'd0);
    reset = 1'b0; cyc = 0; pulses = 0;
    run_to(12);
    check("rh_valid", {31'd0, key_valid}, 32'd1);
    check("rh_code",  {28'd0, key_code},  32'h1);
    run_to(15); reset = 1'b1;
    step();
    check("rh_code_clr", {28'd0, key_code},  32'h0);
    check("rh_held_clr", {31'd0, key_held},  32'd0);
    check("rh_valid0",   {31'd0, key_valid}, 32'd0);
    step();
    check("rh_valid1",   {31'd0, key_valid}, 32'd0);
    check("rh_pulses",   pulses, 1);
    reset = 1'b0;

    // Key A (row0/col3) held ~75 cycles past acceptance: auto-repeat
    pressed = '0; pressed[0*4+3] = 1'b1;
    do_reset();
    run_to(24);
    check("kA_valid", {31'd0, key_valid}, 32'd1);
    check("kA_code",  {28'd0, key_code},  32'hA);
    run_to(63); check("kA_before_rpt", pulses, 1);
    run_to(64); check("kA_rpt64", {31'd0, key_valid}, {31'd0, EXP_RPT64});
    run_to(98); pressed = '0;
    run_to(130);
    check("kA_pulses", pulses, EXP_A_PULSES);
    check("kA_code_hold", {28'd0, key_code}, 32'hA);
    check("kA_released", {31'd0, key_held}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
